// File: rtl/jam_ctrl.sv
// Sequencing controller for the JAM datapath: takes worker-to-job permutations,
// streams the (W, J) cost-table addresses and drives the accumulator strobes.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// FETCH | accepting permutations and issuing W/J addresses
// DRAIN | final address issued; waiting for the last total
// DONE  | one-cycle Valid pulse, then back to IDLE
module jam_ctrl #(
    parameter int N_WORKERS = 8,
    parameter int COST_LAT  = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   perm_valid,
    input  logic [3*N_WORKERS-1:0] perm_jobs,
    input  logic                   perm_last,
    output logic                   perm_ready,
    output logic [2:0]             W,
    output logic [2:0]             J,
    input  logic [7:0]             Cost,
    output logic                   acc_en,
    output logic                   acc_first,
    output logic                   sum_done,
    output logic [15:0]            perm_count,
    output logic                   busy,
    output logic                   Valid
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    localparam logic [2:0] W_LAST = 3'(N_WORKERS - 1);

    state_t                 state;
    logic                   held;
    logic                   held_next;
    logic                   last_taken;
    logic [2:0]             wcnt;
    logic [2:0]             wcnt_next;
    logic [3*N_WORKERS-1:0] jobs_q;
    logic [3*N_WORKERS-1:0] jobs_next;
    logic [COST_LAT-1:0]    tag_v;
    logic [COST_LAT-1:0]    tag_f;
    logic [COST_LAT-1:0]    tag_l;
    logic                   accept;
    logic                   issue;
    logic                   wrap;
    logic                   cost_unused;

    // Cost is consumed by the accumulator; the controller only times it.
    assign cost_unused = ^Cost;

    assign acc_en    = tag_v[COST_LAT-1];
    assign acc_first = tag_f[COST_LAT-1];

    always_comb begin
        perm_ready = (state == S_FETCH) && !last_taken && (!held || (wcnt == W_LAST));
        accept     = perm_valid && perm_ready;
        issue      = (state == S_FETCH) && held;
        wrap       = issue && (wcnt == W_LAST);
        wcnt_next  = wcnt;
        held_next  = held;
        jobs_next  = jobs_q;
        if (issue) begin
            wcnt_next = wrap ? 3'd0 : wcnt + 3'd1;
        end
        if (wrap) begin
            held_next = 1'b0;
        end
        // A new permutation taken on the wrap cycle keeps issue gapless.
        if (accept) begin
            held_next = 1'b1;
            jobs_next = perm_jobs;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            held       <= 1'b0;
            last_taken <= 1'b0;
            wcnt       <= 3'd0;
            jobs_q     <= '0;
            tag_v      <= '0;
            tag_f      <= '0;
            tag_l      <= '0;
            W          <= 3'd0;
            J          <= 3'd0;
            sum_done   <= 1'b0;
            perm_count <= 16'd0;
            busy       <= 1'b0;
            Valid      <= 1'b0;
        end else begin
            tag_v[0] <= issue;
            tag_f[0] <= issue && (wcnt == 3'd0);
            tag_l[0] <= wrap;
            for (int i = 1; i < COST_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_f[i] <= tag_f[i-1];
                tag_l[i] <= tag_l[i-1];
            end
            sum_done <= tag_l[COST_LAT-1];
            if (tag_l[COST_LAT-1] && (perm_count != 16'hFFFF)) begin
                perm_count <= perm_count + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    Valid <= 1'b0;
                    if (start) begin
                        state      <= S_FETCH;
                        busy       <= 1'b1;
                        perm_count <= 16'd0;
                        held       <= 1'b0;
                        last_taken <= 1'b0;
                        wcnt       <= 3'd0;
                    end
                end
                S_FETCH: begin
                    held   <= held_next;
                    wcnt   <= wcnt_next;
                    jobs_q <= jobs_next;
                    if (accept && perm_last) begin
                        last_taken <= 1'b1;
                    end
                    // Addresses are registered one cycle ahead of their issue cycle.
                    if (held_next) begin
                        W <= wcnt_next;
                        J <= jobs_next[3*int'(wcnt_next) +: 3];
                    end
                    if (wrap && last_taken) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Only the final total can complete after the last issue.
                    if (sum_done) begin
                        state <= S_DONE;
                        Valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    Valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_ctrl.sv
// Bench for jam_ctrl: two instances (COST_LAT 1 and 3) share stimulus and are
// checked every cycle against an event-schedule model of the permutation stream.
module tb_jam_ctrl;
    localparam int N    = 8;
    localparam int MAXC = 512;

    logic           CLK        = 1'b0;
    logic           RST        = 1'b1;
    logic           start      = 1'b0;
    logic           perm_valid = 1'b0;
    logic           perm_last  = 1'b0;
    logic [3*N-1:0] perm_jobs  = '0;
    logic [7:0]     Cost       = '0;

    logic        perm_ready_o [2];
    logic [2:0]  w_o          [2];
    logic [2:0]  j_o          [2];
    logic        acc_en_o     [2];
    logic        acc_first_o  [2];
    logic        sum_done_o   [2];
    logic [15:0] count_o      [2];
    logic        busy_o       [2];
    logic        valid_o      [2];

    jam_ctrl #(.N_WORKERS(N), .COST_LAT(1)) dut_l1 (
        .CLK(CLK), .RST(RST), .start(start), .perm_valid(perm_valid),
        .perm_jobs(perm_jobs), .perm_last(perm_last), .perm_ready(perm_ready_o[0]),
        .W(w_o[0]), .J(j_o[0]), .Cost(Cost), .acc_en(acc_en_o[0]),
        .acc_first(acc_first_o[0]), .sum_done(sum_done_o[0]),
        .perm_count(count_o[0]), .busy(busy_o[0]), .Valid(valid_o[0])
    );

    jam_ctrl #(.N_WORKERS(N), .COST_LAT(3)) dut_l3 (
        .CLK(CLK), .RST(RST), .start(start), .perm_valid(perm_valid),
        .perm_jobs(perm_jobs), .perm_last(perm_last), .perm_ready(perm_ready_o[1]),
        .W(w_o[1]), .J(j_o[1]), .Cost(Cost), .acc_en(acc_en_o[1]),
        .acc_first(acc_first_o[1]), .sum_done(sum_done_o[1]),
        .perm_count(count_o[1]), .busy(busy_o[1]), .Valid(valid_o[1])
    );

    always #5 CLK = ~CLK;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    // model: a run is a list of scheduled address issues, indexed by cycle
    int  base        = 0;
    bit  run_on      = 0;
    bit  active [2];
    bit  last_taken  = 0;
    bit  final_known = 0;
    int  final_acc   = 0;
    int  free_at     = 0;
    int  m_count [2];
    bit  accepted_now = 0;
    int  cur_w = 0;
    int  cur_j = 0;
    bit  ev_iss   [MAXC];
    bit  ev_first [MAXC];
    bit  ev_last  [MAXC];
    int  ev_w     [MAXC];
    int  ev_j     [MAXC];

    // observations of the current run, relative to its start cycle
    int sum_rel   [2][8];
    int sum_n     [2];
    int valid_rel [2][4];
    int valid_n   [2];
    int acc_lo    [2];
    int acc_hi    [2];
    int acc_n     [2];
    int first_rel [8];
    int first_n   = 0;
    int j_obs     [MAXC];

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int valid_cyc(int i);
        return final_acc + N + lat_of(i) + 2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_run();
        for (int k = 0; k < MAXC; k++) begin
            ev_iss[k] = 0; ev_first[k] = 0; ev_last[k] = 0;
            ev_w[k] = 0; ev_j[k] = 0; j_obs[k] = -1;
        end
        for (int i = 0; i < 2; i++) begin
            sum_n[i] = 0; valid_n[i] = 0; acc_n[i] = 0; acc_lo[i] = -1; acc_hi[i] = -1;
        end
        first_n = 0;
    endtask

    task automatic model_reset();
        run_on = 0; active[0] = 0; active[1] = 0;
        last_taken = 0; final_known = 0;
        m_count[0] = 0; m_count[1] = 0;
        cur_w = 0; cur_j = 0;
        clear_run();
    endtask

    task automatic check_reset_outputs(input string when);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s L%0d W", when, lat_of(i)), int'(w_o[i]), 0);
            chk($sformatf("%s L%0d J", when, lat_of(i)), int'(j_o[i]), 0);
            chk($sformatf("%s L%0d perm_ready", when, lat_of(i)), int'(perm_ready_o[i]), 0);
            chk($sformatf("%s L%0d acc_en", when, lat_of(i)), int'(acc_en_o[i]), 0);
            chk($sformatf("%s L%0d acc_first", when, lat_of(i)), int'(acc_first_o[i]), 0);
            chk($sformatf("%s L%0d sum_done", when, lat_of(i)), int'(sum_done_o[i]), 0);
            chk($sformatf("%s L%0d perm_count", when, lat_of(i)), int'(count_o[i]), 0);
            chk($sformatf("%s L%0d busy", when, lat_of(i)), int'(busy_o[i]), 0);
            chk($sformatf("%s L%0d Valid", when, lat_of(i)), int'(valid_o[i]), 0);
        end
    endtask

    // Compare this cycle at the falling edge, advance the model, then step past the rising edge.
    task automatic tick();
        int rel;
        int l;
        bit exp_en, exp_first, exp_sum, exp_busy, exp_valid, exp_ready;
        Cost = 8'($urandom);
        @(negedge CLK);
        rel = cyc - base;
        for (int i = 0; i < 2; i++)
            if (active[i] && final_known && cyc > valid_cyc(i)) active[i] = 0;
        if (run_on && !active[0] && !active[1]) run_on = 0;
        if (run_on && rel >= 0 && rel < MAXC && ev_iss[rel]) begin
            cur_w = ev_w[rel];
            cur_j = ev_j[rel];
        end
        for (int i = 0; i < 2; i++) begin
            l = lat_of(i);
            exp_en    = active[i] && (rel - l >= 0) && (rel - l < MAXC) && ev_iss[rel - l];
            exp_first = exp_en && ev_first[rel - l];
            exp_sum   = active[i] && (rel - l - 1 >= 0) && (rel - l - 1 < MAXC) && ev_last[rel - l - 1];
            if (exp_sum && m_count[i] < 65535) m_count[i]++;
            exp_busy  = active[i] && (cyc > base);
            exp_valid = active[i] && final_known && (cyc == valid_cyc(i));
            exp_ready = exp_busy && !last_taken && (cyc >= free_at);
            chk($sformatf("L%0d W", l), int'(w_o[i]), cur_w);
            chk($sformatf("L%0d J", l), int'(j_o[i]), cur_j);
            chk($sformatf("L%0d perm_ready", l), int'(perm_ready_o[i]), int'(exp_ready));
            chk($sformatf("L%0d acc_en", l), int'(acc_en_o[i]), int'(exp_en));
            chk($sformatf("L%0d acc_first", l), int'(acc_first_o[i]), int'(exp_first));
            chk($sformatf("L%0d sum_done", l), int'(sum_done_o[i]), int'(exp_sum));
            chk($sformatf("L%0d perm_count", l), int'(count_o[i]), m_count[i]);
            chk($sformatf("L%0d busy", l), int'(busy_o[i]), int'(exp_busy));
            chk($sformatf("L%0d Valid", l), int'(valid_o[i]), int'(exp_valid));
            if (rel >= 0) begin
                if (sum_done_o[i]) begin
                    if (sum_n[i] < 8) sum_rel[i][sum_n[i]] = rel;
                    sum_n[i]++;
                end
                if (valid_o[i]) begin
                    if (valid_n[i] < 4) valid_rel[i][valid_n[i]] = rel;
                    valid_n[i]++;
                end
                if (acc_en_o[i]) begin
                    if (acc_n[i] == 0) acc_lo[i] = rel;
                    acc_hi[i] = rel;
                    acc_n[i]++;
                end
            end
        end
        if (rel >= 0 && rel < MAXC) j_obs[rel] = int'(j_o[0]);
        if (rel >= 0 && acc_first_o[0]) begin
            if (first_n < 8) first_rel[first_n] = rel;
            first_n++;
        end

        accepted_now = 0;
        if (run_on && active[0] && cyc > base && !last_taken && cyc >= free_at && perm_valid) begin
            accepted_now = 1;
            for (int k = 0; k < N; k++) begin
                if (rel + 1 + k < MAXC) begin
                    ev_iss[rel + 1 + k]   = 1;
                    ev_w[rel + 1 + k]     = k;
                    ev_j[rel + 1 + k]     = int'(perm_jobs[3*k +: 3]);
                    ev_first[rel + 1 + k] = (k == 0);
                    ev_last[rel + 1 + k]  = (k == N - 1);
                end
            end
            free_at = cyc + N;
            if (perm_last) begin
                last_taken  = 1;
                final_known = 1;
                final_acc   = cyc;
            end
        end
        if (start && !run_on) begin
            clear_run();
            run_on = 1; active[0] = 1; active[1] = 1;
            base = cyc; last_taken = 0; final_known = 0;
            free_at = cyc + 1;
            m_count[0] = 0; m_count[1] = 0;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic offer(input logic [3*N-1:0] jobs, input bit last, input int pre_idle);
        int n;
        n = 0;
        perm_valid = 1'b0;
        repeat (pre_idle) tick();
        perm_valid = 1'b1;
        perm_jobs  = jobs;
        perm_last  = last;
        accepted_now = 0;
        while (!accepted_now && n < 64) begin
            tick();
            n++;
        end
        perm_valid = 1'b0;
        perm_last  = 1'b0;
        if (!accepted_now) begin
            tests++;
            errors++;
            $display("FAIL offer: permutation not accepted within %0d cycles", n);
        end
    endtask

    // Runs out the drain with ignored offers and one ignored start pulse.
    task automatic wait_done();
        int n;
        n = 0;
        while (run_on && n < 300) begin
            perm_valid = 1'($urandom_range(0, 1));
            perm_last  = 1'($urandom_range(0, 1));
            perm_jobs  = 24'($urandom);
            start      = final_known && (cyc == final_acc + N + 2);
            tick();
            n++;
        end
        start = 1'b0; perm_valid = 1'b0; perm_last = 1'b0;
        if (run_on) begin
            tests++;
            errors++;
            $display("FAIL wait_done: run still active after %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3*N-1:0] desc_jobs;
    logic [3*N-1:0] rjobs;
    int np;
    int pre;

    initial begin
        model_reset();
        for (int k = 0; k < N; k++) desc_jobs[3*k +: 3] = 3'(N - 1 - k);

        #1 RST = 1'b0;
        #2 check_reset_outputs("reset");
        @(posedge CLK);
        #1;
        repeat (3) tick();
        RST = 1'b1;
        repeat (20) tick();
        chk("idle busy", int'(busy_o[0]) + int'(busy_o[1]), 0);

        // single permutation {7..0}
        start_run();
        offer(desc_jobs, 1'b1, 0);
        wait_done();
        chk("A L1 sum_done count", sum_n[0], 1);
        chk("A L1 sum_done cycle", sum_rel[0][0], 11);
        chk("A L1 Valid cycle", valid_rel[0][0], 12);
        chk("A L1 acc_first count", first_n, 1);
        chk("A L1 acc_first cycle", first_rel[0], 3);
        chk("A J at cycle 2", j_obs[2], 7);
        chk("A J at cycle 9", j_obs[9], 0);
        chk("A L3 acc_en first", acc_lo[1], 5);
        chk("A L3 acc_en last", acc_hi[1], 12);
        chk("A L3 sum_done cycle", sum_rel[1][0], 13);
        chk("A L3 Valid count", valid_n[1], 1);
        chk("A L3 Valid cycle", valid_rel[1][0], 14);
        chk("A perm_count", int'(count_o[0]), 1);
        tick();

        // three back-to-back permutations
        start_run();
        offer(24'($urandom), 1'b0, 0);
        offer(24'($urandom), 1'b0, 0);
        offer(24'($urandom), 1'b1, 0);
        wait_done();
        chk("B sum_done count", sum_n[0], 3);
        chk("B sum_done 1", sum_rel[0][0], 11);
        chk("B sum_done 2", sum_rel[0][1], 19);
        chk("B sum_done 3", sum_rel[0][2], 27);
        chk("B acc_en span", acc_hi[0] - acc_lo[0] + 1, 24);
        chk("B Valid count", valid_n[0], 1);
        chk("B perm_count", int'(count_o[0]), 3);
        tick();

        // five-cycle perm_valid gap at the boundary
        start_run();
        offer(24'($urandom), 1'b0, 0);
        offer(24'($urandom), 1'b1, N - 1 + 5);
        wait_done();
        chk("C idle acc_en cycles", acc_hi[0] - acc_lo[0] + 1 - acc_n[0], 5);
        chk("C sum_done count", sum_n[0], 2);
        chk("C sum_done 2", sum_rel[0][1], 24);
        chk("C acc_first 1", first_rel[0], 3);
        chk("C acc_first 2", first_rel[1], 16);
        tick();

        // reset mid-FETCH, then a fresh run
        start_run();
        offer(24'($urandom), 1'b0, 0);
        repeat (4) tick();
        #2 RST = 1'b0;
        #1 check_reset_outputs("mid-run reset");
        model_reset();
        repeat (2) tick();
        RST = 1'b1;
        tick();
        start_run();
        offer(desc_jobs, 1'b1, 0);
        wait_done();
        chk("D perm_count after rerun", int'(count_o[0]), 1);
        chk("D Valid count", valid_n[0], 1);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            start_run();
            np = $urandom_range(1, 5);
            for (int p = 0; p < np; p++) begin
                pre = (p == 0 || $urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 14);
                rjobs = 24'($urandom);
                offer(rjobs, (p == np - 1), pre);
            end
            wait_done();
            chk($sformatf("R%0d perm_count", r), int'(count_o[1]), np);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/jam_ctrl.md
# jam_ctrl

Sequencing controller for the job-assignment (JAM) datapath. It accepts worker-to-job permutations from the permutation generator through a valid/ready handshake and issues the eight (W, J) cost-table addresses per permutation back to back. It drives the accumulator with aligned enable, first and last strobes, and pulses `sum_done` to the result stage after each total. It asserts `Valid` once the final permutation has been summed.

## Interface
- `N_WORKERS`, default 8: workers and jobs per permutation. The W/J width is fixed at 3 bits, so N_WORKERS ≤ 8.
- `COST_LAT`, default 1: cycles from a W/J presentation to Cost being valid. Range 1–4.

Ports:
- `CLK` in 1: the single clock; all state updates on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a run; sampled only in IDLE.
- `perm_valid` in 1: a permutation is offered.
- `perm_jobs` in 3*N_WORKERS: job index for worker k is in bits [3k+2:3k].
- `perm_last` in 1: the offered permutation is the final one; qualified by `perm_valid`.
- `perm_ready` out 1: the controller accepts the offer this cycle.
- `W` out 3: worker address to the cost table.
- `J` out 3: job address to the cost table.
- `Cost` in 8: cost table data, arriving COST_LAT cycles after its address.
- `acc_en` out 1: the accumulator samples `Cost` this cycle.
- `acc_first` out 1: with `acc_en`, load `Cost` instead of adding it.
- `sum_done` out 1: pulse; the accumulator holds a complete permutation total.
- `perm_count` out 16: number of completed totals this run; saturates at 65535.
- `busy` out 1: high in every state other than IDLE.
- `Valid` out 1: single-cycle pulse marking the end of the run.

## Operation
- States are IDLE, FETCH, DRAIN and DONE.
- IDLE → FETCH on `start`. Entering FETCH clears `perm_count`, `held` and `last_taken`.
- `perm_ready` = FETCH && !`last_taken` && (!`held` || `wcnt`==N_WORKERS-1).
- Acceptance (`perm_valid` && `perm_ready`) does the following:
  - latches `perm_jobs` into `jobs_q`;
  - sets `held`;
  - sets `last_taken` if `perm_last` is high.
- Issue happens in every FETCH cycle with `held`=1:
  - `W` = `wcnt`; `J` = `jobs_q[wcnt]`.
  - `wcnt` increments each issue. At N_WORKERS-1 it wraps to 0 and clears `held`, unless a new permutation is accepted in the same cycle.
  - Consecutive permutations therefore issue with no bubble.
- When `held`=0, `W`/`J` hold their last values and no issue is tagged. Costs already in flight still complete.
- FETCH → DRAIN when the final issue occurs: `last_taken` set and `wcnt`==N_WORKERS-1.
- Issue tags (valid, first = `wcnt`==0, last = `wcnt`==N_WORKERS-1) pass through a COST_LAT-deep shift register:
  - `acc_en` = delayed valid;
  - `acc_first` = delayed valid && first.
- `sum_done` is registered one cycle after a delayed last tag. `perm_count` increments in that same cycle.
- DRAIN → DONE in the cycle after the `sum_done` of the final permutation.
- DONE holds `Valid`=1 for one cycle, then returns to IDLE.
- `start` outside IDLE is ignored.
- `perm_last` is ignored once `last_taken` is set.
- `W`, `J` and all strobes come from registers. There is no combinational path from inputs to outputs, except `perm_ready` from `perm_valid` being absent; `perm_ready` depends only on state.

## Timing
- Reset values: state IDLE; `W`=0, `J`=0; `perm_ready`=0; `acc_en`=0, `acc_first`=0; `sum_done`=0; `perm_count`=0; `busy`=0; `Valid`=0. The tag pipeline and `jobs_q` are cleared.
- Single-permutation run, `start` at cycle 0:
  - FETCH from cycle 1; `perm_ready`=1 in cycle 1; offer accepted in cycle 1.
  - W=0..7 in cycles 2–9.
  - `acc_en` in cycles 2+COST_LAT through 9+COST_LAT.
  - `sum_done` at 10+COST_LAT; `Valid` at 11+COST_LAT; IDLE at 12+COST_LAT.
- Steady-state throughput is one permutation per N_WORKERS cycles.
- A `perm_valid` gap of g cycles at a boundary inserts exactly g idle issue cycles.
- `RST` low at any point returns every register to its reset value immediately. No `Valid` is produced for an interrupted run.

## Test plan
- Reset then idle: all outputs at reset values; a `start` held off for 20 cycles leaves `busy`=0.
- COST_LAT=1, one permutation jobs {7,6,5,4,3,2,1,0} with `perm_last`=1, `start` at cycle 0:
  - J=7..0 in cycles 2–9;
  - `acc_first` only at cycle 3;
  - `sum_done` at 11, `Valid` at 12, `perm_count`=1.
- Three permutations offered continuously, last one tagged `perm_last`:
  - W runs 0–7 three times with no gap;
  - three `sum_done` pulses spaced 8 cycles apart; `perm_count`=3; one `Valid`.
- `perm_valid` dropped for 5 cycles between permutations:
  - exactly 5 cycles without `acc_en`;
  - no `sum_done` until the second total completes;
  - `acc_first` asserted correctly after the gap.
- `RST` pulsed low mid-FETCH: outputs return to reset values at once; no `Valid`; a fresh `start` reruns from `perm_count`=0.
- COST_LAT=3, one permutation: `acc_en` in cycles 5–12, `sum_done` at 13, `Valid` at 14; `start` asserted during DRAIN is ignored.
